// File: rtl/max_reduce_sched.sv
// Frame-based max-reduction scheduler driving a shared zero-latency 2-operand max datapath.
// Optional approximation-error monitor: define MAX_REDUCE_ERR_MON_EN.
module max_reduce_sched #(
   parameter int DW    = 4,
   parameter int CNT_W = 8,
   parameter int ERR_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DW-1:0]    in_data,
   input  logic             in_last,
   output logic [DW-1:0]    dp_a,
   output logic [DW-1:0]    dp_b,
   input  logic [DW:0]      dp_res,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [DW-1:0]    out_max,
   output logic [CNT_W-1:0] out_idx,
   output logic [CNT_W-1:0] out_count,
   output logic             out_ovf,
   output logic [ERR_W-1:0] err_count
);

   typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state, state_nxt;
   logic             accept;
   logic [DW-1:0]    acc, acc_nxt;
   logic [CNT_W-1:0] idx, idx_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             ovf, ovf_nxt;

   function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_ONE;
   endfunction

   assign dp_a   = acc;
   assign dp_b   = in_data;
   assign accept = in_valid & in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, ACCUM: if (accept) state_nxt = in_last ? OUT : ACCUM;
         OUT:         if (out_ready) state_nxt = IDLE;
         default:     state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state != OUT);
      out_valid = (state == OUT);
   end

   // First beat seeds the accumulator; later beats take the datapath result.
   // Once the count saturates the winning index can no longer be tracked, so it freezes.
   always_comb begin
      acc_nxt = acc;
      idx_nxt = idx;
      cnt_nxt = cnt;
      ovf_nxt = ovf;
      if (accept) begin
         if (state == IDLE) begin
            acc_nxt = in_data;
            idx_nxt = '0;
            cnt_nxt = CNT_ONE;
            ovf_nxt = 1'b0;
         end else begin
            acc_nxt = dp_res[DW-1:0];
            if (dp_res[DW] && !ovf) idx_nxt = cnt;
            cnt_nxt = sat_inc_cnt(cnt);
            if (cnt == CNT_MAX) ovf_nxt = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
         idx <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end else begin
         acc <= acc_nxt;
         idx <= idx_nxt;
         cnt <= cnt_nxt;
         ovf <= ovf_nxt;
      end
   end

   // Result registers load on the closing beat and hold until the next frame closes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_max   <= '0;
         out_idx   <= '0;
         out_count <= '0;
         out_ovf   <= 1'b0;
      end else if (accept && in_last) begin
         out_max   <= acc_nxt;
         out_idx   <= idx_nxt;
         out_count <= cnt_nxt;
         out_ovf   <= ovf_nxt;
      end
   end

`ifdef MAX_REDUCE_ERR_MON_EN
   localparam logic [ERR_W-1:0] ERR_MAX = '1;
   localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);

   logic [DW-1:0] exact_max;

   function automatic logic [ERR_W-1:0] sat_inc_err(input logic [ERR_W-1:0] v);
      return (v == ERR_MAX) ? v : v + ERR_ONE;
   endfunction

   assign exact_max = (in_data > acc) ? in_data : acc;

   // Monitor only: the approximate result still feeds the accumulator.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         err_count <= '0;
      else if (accept && (state == ACCUM) && (exact_max != dp_res[DW-1:0]))
         err_count <= sat_inc_err(err_count);
   end
`else
   assign err_count = '0;
`endif

endmodule

// File: tb/tb_max_reduce_sched.sv
// Self-checking bench for max_reduce_sched: table-driven frames plus hand sequences, scoreboard on results.
module tb_max_reduce_sched;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid, in_last, out_ready, approx;
   logic [3:0] in_data;

   logic       in_ready0, out_valid0, out_ovf0;
   logic [3:0] dp_a0, dp_b0, out_max0;
   logic [4:0] dp_res0;
   logic [7:0] out_idx0, out_count0;
   logic [15:0] err_count0;

   logic       in_ready1, out_valid1, out_ovf1;
   logic [3:0] dp_a1, dp_b1, out_max1;
   logic [4:0] dp_res1;
   logic [1:0] out_idx1, out_count1;
   logic [15:0] err_count1;

`ifdef MAX_REDUCE_ERR_MON_EN
   localparam int ERR_EXP = 2;
`else
   localparam int ERR_EXP = 0;
`endif

   typedef struct packed {
      logic [31:0] d;
      logic [3:0]  len;
      logic [3:0]  emax;
      logic [7:0]  eidx;
      logic [7:0]  ecnt;
      logic        eovf;
   } vec_t;

   typedef struct packed {
      logic [3:0] mx;
      logic [7:0] idx;
      logic [7:0] cnt;
      logic       ovf;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   // Reference datapath; in approximate mode it wrongly keeps A whenever B is larger.
   function automatic logic [4:0] dp_model(input logic [3:0] a, input logic [3:0] b, input logic ap);
      if (b > a) return ap ? {1'b0, a} : {1'b1, b};
      return {1'b0, a};
   endfunction

   assign dp_res0 = dp_model(dp_a0, dp_b0, approx);
   assign dp_res1 = dp_model(dp_a1, dp_b1, approx);

   max_reduce_sched #(.DW(4), .CNT_W(8), .ERR_W(16)) dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
      .in_data(in_data), .in_last(in_last), .dp_a(dp_a0), .dp_b(dp_b0), .dp_res(dp_res0),
      .out_valid(out_valid0), .out_ready(out_ready), .out_max(out_max0), .out_idx(out_idx0),
      .out_count(out_count0), .out_ovf(out_ovf0), .err_count(err_count0)
   );

   max_reduce_sched #(.DW(4), .CNT_W(2), .ERR_W(16)) dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
      .in_data(in_data), .in_last(in_last), .dp_a(dp_a1), .dp_b(dp_b1), .dp_res(dp_res1),
      .out_valid(out_valid1), .out_ready(out_ready), .out_max(out_max1), .out_idx(out_idx1),
      .out_count(out_count1), .out_ovf(out_ovf1), .err_count(err_count1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (out_valid0 && out_ready) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_unexpected: got result max %0d expected none", out_max0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("res_max", 32'(out_max0), 32'(e.mx));
            chk("res_idx", 32'(out_idx0), 32'(e.idx));
            chk("res_cnt", 32'(out_count0), 32'(e.cnt));
            chk("res_ovf", 32'(out_ovf0), 32'(e.ovf));
         end
      end
   end

   task automatic beat(input logic [3:0] d, input logic l);
      int t = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      while (!in_ready0 && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) begin
         tests++;
         fails++;
         $display("FAIL beat_timeout: got in_ready 0 expected 1");
      end
      @(posedge clk);
      #1;
      if (l) in_valid = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while (sb.size() != 0 && t < 40) begin
         @(negedge clk);
         t++;
      end
      if (t >= 40) begin
         tests++;
         fails++;
         $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      end
      @(negedge clk);
   endtask

   task automatic send_frame(input vec_t v);
      exp_t e;
      for (int i = 0; i < int'(v.len); i++) begin
         if (i == int'(v.len) - 1) begin
            e.mx = v.emax; e.idx = v.eidx; e.cnt = v.ecnt; e.ovf = v.eovf;
            sb.push_back(e);
         end
         beat(v.d[4*i +: 4], (i == int'(v.len) - 1));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[6];
      exp_t e;
      tbl[0] = '{d: 32'h0000_9293, len: 4'd4, emax: 4'd9,  eidx: 8'd1, ecnt: 8'd4, eovf: 1'b0};
      tbl[1] = '{d: 32'h0000_0007, len: 4'd1, emax: 4'd7,  eidx: 8'd0, ecnt: 8'd1, eovf: 1'b0};
      tbl[2] = '{d: 32'h0083_8441, len: 4'd7, emax: 4'd8,  eidx: 8'd3, ecnt: 8'd7, eovf: 1'b0};
      tbl[3] = '{d: 32'h0000_0F0F, len: 4'd3, emax: 4'd15, eidx: 8'd0, ecnt: 8'd3, eovf: 1'b0};
      tbl[4] = '{d: 32'h0000_0000, len: 4'd2, emax: 4'd0,  eidx: 8'd0, ecnt: 8'd2, eovf: 1'b0};
      tbl[5] = '{d: 32'h9876_5432, len: 4'd8, emax: 4'd9,  eidx: 8'd7, ecnt: 8'd8, eovf: 1'b0};

      rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 4'd0;
      out_ready = 1'b1; approx = 1'b0;
      #12;
      chk("rst_out_valid", 32'(out_valid0), 32'd0);
      chk("rst_in_ready", 32'(in_ready0), 32'd1);
      chk("rst_out_max", 32'(out_max0), 32'd0);
      chk("rst_out_count", 32'(out_count0), 32'd0);
      chk("rst_err", 32'(err_count0), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int k = 0; k < 6; k++) begin
         send_frame(tbl[k]);
         if (k == 1) chk("latency_valid", 32'(out_valid0), 32'd1);
         drain();
      end

      // Result held while consumer stalls
      out_ready = 1'b0;
      e.mx = 4'd11; e.idx = 8'd1; e.cnt = 8'd2; e.ovf = 1'b0;
      sb.push_back(e);
      beat(4'd5, 1'b0);
      beat(4'd11, 1'b1);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("hold_valid", 32'(out_valid0), 32'd1);
         chk("hold_in_ready", 32'(in_ready0), 32'd0);
         chk("hold_max", 32'(out_max0), 32'd11);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      drain();
      chk("hold_back_idle", 32'(in_ready0), 32'd1);
      chk("hold_valid_drop", 32'(out_valid0), 32'd0);

      // Count saturation on the narrow-counter instance
      e.mx = 4'd5; e.idx = 8'd1; e.cnt = 8'd5; e.ovf = 1'b0;
      sb.push_back(e);
      beat(4'd1, 1'b0); beat(4'd5, 1'b0); beat(4'd2, 1'b0); beat(4'd3, 1'b0); beat(4'd4, 1'b1);
      chk("ovf_valid", 32'(out_valid1), 32'd1);
      chk("ovf_count", 32'(out_count1), 32'd3);
      chk("ovf_flag", 32'(out_ovf1), 32'd1);
      chk("ovf_max", 32'(out_max1), 32'd5);
      chk("ovf_idx", 32'(out_idx1), 32'd1);
      drain();

      // Approximate datapath misses the larger operand on two beats
      approx = 1'b1;
      e.mx = 4'd2; e.idx = 8'd0; e.cnt = 8'd3; e.ovf = 1'b0;
      sb.push_back(e);
      beat(4'd2, 1'b0); beat(4'd5, 1'b0); beat(4'd7, 1'b1);
      drain();
      approx = 1'b0;
      chk("err_count", 32'(err_count0), 32'(ERR_EXP));

      // Asynchronous reset in the middle of a frame
      beat(4'd6, 1'b0);
      beat(4'd3, 1'b0);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(out_valid0), 32'd0);
      chk("arst_max", 32'(out_max0), 32'd0);
      chk("arst_idx", 32'(out_idx0), 32'd0);
      chk("arst_count", 32'(out_count0), 32'd0);
      chk("arst_err", 32'(err_count0), 32'd0);
      chk("arst_dp_a", 32'(dp_a0), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      e.mx = 4'd2; e.idx = 8'd1; e.cnt = 8'd2; e.ovf = 1'b0;
      sb.push_back(e);
      beat(4'd1, 1'b0); beat(4'd2, 1'b1);
      drain();

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
